// File: rtl/thread_fetch_unit.sv
// Fine-grained multithreaded PC/fetch sequencer: one PC per hardware thread,
// round-robin issue with a per-thread lockout after every fetch.
module thread_fetch_unit #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          NUM_THREADS = 4,
  parameter int unsigned          TID_WIDTH   = 2,
  parameter int unsigned          PC_STEP     = 4,
  parameter int unsigned          BR_SHADOW   = 3,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pc_en,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   set_pc_valid,
  input  logic [TID_WIDTH-1:0]   set_pc_tid,
  input  logic [PC_WIDTH-1:0]    set_pc_value,
  input  logic                   redirect_valid,
  input  logic [TID_WIDTH-1:0]   redirect_tid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   fetch_valid,
  output logic [TID_WIDTH-1:0]   fetch_tid,
  output logic [PC_WIDTH-1:0]    fetch_pc,
  output logic [NUM_THREADS-1:0] thread_ready
);

  localparam int unsigned           LOCK_WIDTH = 4;
  localparam logic [LOCK_WIDTH-1:0] LOCK_LOAD  = LOCK_WIDTH'(BR_SHADOW);
  localparam logic [LOCK_WIDTH-1:0] LOCK_ONE   = LOCK_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0]   PC_INC     = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]    pc_q   [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_d   [NUM_THREADS];
  logic [LOCK_WIDTH-1:0]  lock_q [NUM_THREADS];
  logic [LOCK_WIDTH-1:0]  lock_d [NUM_THREADS];
  logic [TID_WIDTH-1:0]   rr_q, rr_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [TID_WIDTH-1:0]   fetch_tid_q, fetch_tid_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;

  logic [NUM_THREADS-1:0] set_hit;
  logic [NUM_THREADS-1:0] redir_hit;
  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] sel_oh;
  logic                   found;
  logic [TID_WIDTH-1:0]   sel_tid;
  logic [TID_WIDTH-1:0]   rr_nxt;
  logic [PC_WIDTH-1:0]    sel_pc;

  // Out-of-range tids never match any thread index, so they drop out here.
  always_comb begin
    set_hit   = '0;
    redir_hit = '0;
    elig      = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      set_hit[t]   = set_pc_valid   && (set_pc_tid   == TID_WIDTH'(t));
      redir_hit[t] = redirect_valid && (redirect_tid == TID_WIDTH'(t));
      elig[t]      = thread_en[t] && (lock_q[t] == '0) && !set_hit[t] && !redir_hit[t];
    end
  end

  // Round-robin scan written with constant indices only: step k of the scan
  // visits thread (rr_q + k) mod NUM_THREADS, first eligible one wins.
  always_comb begin
    found   = 1'b0;
    sel_oh  = '0;
    sel_tid = '0;
    rr_nxt  = rr_q;
    sel_pc  = '0;
    for (int unsigned k = 0; k < NUM_THREADS; k++) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        if (!found && elig[t] && (t == ((32'(rr_q) + k) % NUM_THREADS))) begin
          found     = 1'b1;
          sel_oh[t] = 1'b1;
          sel_tid   = TID_WIDTH'(t);
          rr_nxt    = TID_WIDTH'((t + 1) % NUM_THREADS);
          sel_pc    = pc_q[t];
        end
      end
    end
  end

  always_comb begin
    pc_d          = pc_q;
    lock_d        = lock_q;
    rr_d          = rr_q;
    fetch_valid_d = fetch_valid_q;
    fetch_tid_d   = fetch_tid_q;
    fetch_pc_d    = fetch_pc_q;

    if (pc_en) begin
      fetch_valid_d = found;
      if (found) begin
        fetch_tid_d = sel_tid;
        fetch_pc_d  = sel_pc;
        rr_d        = rr_nxt;
      end
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        if (sel_oh[t]) begin
          pc_d[t]   = pc_q[t] + PC_INC;
          lock_d[t] = LOCK_LOAD;
        end else if (lock_q[t] != '0) begin
          lock_d[t] = lock_q[t] - LOCK_ONE;
        end
      end
    end

    // Selected thread can never be a set/redirect target, so these writes
    // never collide with the increment above; set_pc is applied last to win.
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (redir_hit[t]) begin
        pc_d[t] = redirect_pc;
      end
      if (set_hit[t]) begin
        pc_d[t]   = set_pc_value;
        lock_d[t] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t]   <= RESET_PC;
        lock_q[t] <= '0;
      end
      rr_q          <= '0;
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= '0;
      fetch_pc_q    <= '0;
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t]   <= pc_d[t];
        lock_q[t] <= lock_d[t];
      end
      rr_q          <= rr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_tid_q   <= fetch_tid_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign fetch_valid  = fetch_valid_q;
  assign fetch_tid    = fetch_tid_q;
  assign fetch_pc     = fetch_pc_q;
  assign thread_ready = elig;

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Bench for thread_fetch_unit: a 4-thread instance against a behavioural
// model, plus a single-thread instance checked against the 1-in-4 fetch pattern.
module tb_thread_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        pc_en;
  logic [3:0]  thread_en;
  logic        set_pc_valid;
  logic [1:0]  set_pc_tid;
  logic [31:0] set_pc_value;
  logic        redirect_valid;
  logic [1:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [1:0]  fetch_tid;
  logic [31:0] fetch_pc;
  logic [3:0]  thread_ready;

  logic        f1_valid;
  logic        f1_tid;
  logic [31:0] f1_pc;
  logic        f1_ready;

  int tests = 0;
  int fails = 0;

  thread_fetch_unit #(
    .PC_WIDTH(32), .NUM_THREADS(4), .TID_WIDTH(2),
    .PC_STEP(4), .BR_SHADOW(3), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pc_en(pc_en), .thread_en(thread_en),
    .set_pc_valid(set_pc_valid), .set_pc_tid(set_pc_tid), .set_pc_value(set_pc_value),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_tid(fetch_tid), .fetch_pc(fetch_pc),
    .thread_ready(thread_ready)
  );

  // Single thread; set/redirect permanently aimed at the nonexistent tid 1.
  thread_fetch_unit #(
    .PC_WIDTH(32), .NUM_THREADS(1), .TID_WIDTH(1),
    .PC_STEP(4), .BR_SHADOW(3), .RESET_PC(32'h0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .pc_en(1'b1), .thread_en(1'b1),
    .set_pc_valid(1'b1), .set_pc_tid(1'b1), .set_pc_value(32'h500),
    .redirect_valid(1'b1), .redirect_tid(1'b1), .redirect_pc(32'h900),
    .fetch_valid(f1_valid), .fetch_tid(f1_tid), .fetch_pc(f1_pc),
    .thread_ready(f1_ready)
  );

  // Reference model state
  logic [31:0] m_pc [4];
  int          m_lock [4];
  int          m_rr;
  logic        m_fv;
  int          m_ftid;
  logic [31:0] m_fpc;
  int          j1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_elig();
    logic [3:0] e;
    for (int t = 0; t < 4; t++) begin
      e[t] = thread_en[t] && (m_lock[t] == 0)
             && !(redirect_valid && int'(redirect_tid) == t)
             && !(set_pc_valid && int'(set_pc_tid) == t);
    end
    return e;
  endfunction

  task automatic model_step();
    logic [3:0] el;
    int sel;
    if (!reset_n) begin
      for (int t = 0; t < 4; t++) begin
        m_pc[t]   = 32'h0;
        m_lock[t] = 0;
      end
      m_rr = 0; m_fv = 1'b0; m_ftid = 0; m_fpc = 32'h0;
      return;
    end
    el  = m_elig();
    sel = -1;
    if (pc_en) begin
      for (int k = 0; k < 4; k++)
        if (sel < 0 && el[(m_rr + k) % 4]) sel = (m_rr + k) % 4;
      for (int t = 0; t < 4; t++)
        if (t != sel && m_lock[t] > 0) m_lock[t]--;
      if (sel >= 0) begin
        m_fv = 1'b1; m_ftid = sel; m_fpc = m_pc[sel];
        m_pc[sel] = m_pc[sel] + 32'd4;
        m_lock[sel] = 3;
        m_rr = (sel + 1) % 4;
      end else begin
        m_fv = 1'b0;
      end
    end
    if (redirect_valid) m_pc[redirect_tid] = redirect_pc;
    if (set_pc_valid) begin
      m_pc[set_pc_tid]   = set_pc_value;
      m_lock[set_pc_tid] = 0;
    end
  endtask

  task automatic tick(input bit chk_ready = 1'b1);
    logic rst_s;
    #1;
    if (chk_ready) begin
      check("ready", {28'b0, thread_ready}, {28'b0, m_elig()});
      check("n1_ready", {31'b0, f1_ready}, {31'b0, (j1 % 4) == 0});
    end
    @(posedge clk);
    rst_s = reset_n;
    model_step();
    #1;
    check("valid", {31'b0, fetch_valid}, {31'b0, m_fv});
    check("tid", {30'b0, fetch_tid}, 32'(m_ftid));
    check("pc", fetch_pc, m_fpc);
    if (!rst_s) begin
      j1 = 0;
      check("n1_rst_valid", {31'b0, f1_valid}, 32'h0);
      check("n1_rst_pc", f1_pc, 32'h0);
    end else begin
      check("n1_valid", {31'b0, f1_valid}, {31'b0, (j1 % 4) == 0});
      check("n1_pc", f1_pc, 32'(4 * (j1 / 4)));
      check("n1_tid", {31'b0, f1_tid}, 32'h0);
      j1++;
    end
  endtask

  // Runs up to max_ticks cycles and captures the first two fetch PCs of tid.
  task automatic run_collect(input int tid, input int max_ticks,
                             output logic [31:0] p0, output logic [31:0] p1, output int cnt);
    cnt = 0; p0 = 32'h0; p1 = 32'h0;
    for (int i = 0; i < max_ticks && cnt < 2; i++) begin
      tick();
      if (fetch_valid && int'(fetch_tid) == tid) begin
        if (cnt == 0) p0 = fetch_pc; else p1 = fetch_pc;
        cnt++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p0, p1;
    int cnt;
    bit found;

    j1 = 0;
    reset_n = 1'b0; pc_en = 1'b1; thread_en = 4'b1111;
    set_pc_valid = 1'b0; set_pc_tid = '0; set_pc_value = '0;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    for (int t = 0; t < 4; t++) begin m_pc[t] = '0; m_lock[t] = 0; end
    m_rr = 0; m_fv = 1'b0; m_ftid = 0; m_fpc = '0;

    tick(1'b0);
    tick();
    check("reset_valid", {31'b0, fetch_valid}, 32'h0);

    // All threads running: one fetch per cycle, round robin
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("rr_last_tid", {30'b0, fetch_tid}, 32'd3);
    check("rr_last_pc", fetch_pc, 32'h4);

    // Threads 0 and 2 only: bubbles in the lockout gap
    thread_en = 4'b0101;
    for (int i = 0; i < 10; i++) tick();

    // Redirect tid1 one cycle after it issues
    thread_en = 4'b1111;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (fetch_valid && fetch_tid == 2'd1) found = 1'b1;
    end
    check("wait_tid1", {31'b0, found}, 32'h1);
    redirect_valid = 1'b1; redirect_tid = 2'd1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    run_collect(1, 16, p0, p1, cnt);
    check("redir_cnt", 32'(cnt), 32'd2);
    check("redir_pc0", p0, 32'h100);
    check("redir_pc1", p1, 32'h104);

    // Stall mid-stream, then resume
    pc_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    pc_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // set_pc and redirect on the same thread: set_pc wins
    set_pc_valid = 1'b1; set_pc_tid = 2'd2; set_pc_value = 32'h2000;
    redirect_valid = 1'b1; redirect_tid = 2'd2; redirect_pc = 32'h3000;
    tick();
    set_pc_valid = 1'b0; redirect_valid = 1'b0;
    run_collect(2, 16, p0, p1, cnt);
    check("setwin_pc0", p0, 32'h2000);
    check("setwin_pc1", p1, 32'h2004);

    // set_pc and redirect on different threads in one cycle
    set_pc_valid = 1'b1; set_pc_tid = 2'd3; set_pc_value = 32'h700;
    redirect_valid = 1'b1; redirect_tid = 2'd1; redirect_pc = 32'h800;
    tick();
    set_pc_valid = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // PC wrap
    set_pc_valid = 1'b1; set_pc_tid = 2'd0; set_pc_value = 32'hFFFF_FFFC;
    tick();
    set_pc_valid = 1'b0;
    run_collect(0, 16, p0, p1, cnt);
    check("wrap_cnt", 32'(cnt), 32'd2);
    check("wrap_pc0", p0, 32'hFFFF_FFFC);
    check("wrap_pc1", p1, 32'h0);

    // Mid-stream reset
    reset_n = 1'b0;
    tick();
    check("mrst_valid", {31'b0, fetch_valid}, 32'h0);
    check("mrst_pc", fetch_pc, 32'h0);
    reset_n = 1'b1;
    tick();
    check("mrst_first_valid", {31'b0, fetch_valid}, 32'h1);
    check("mrst_first_tid", {30'b0, fetch_tid}, 32'h0);
    check("mrst_first_pc", fetch_pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      thread_en      = 4'($urandom);
      pc_en          = ($urandom_range(0, 7) != 0);
      set_pc_valid   = ($urandom_range(0, 9) == 0);
      set_pc_tid     = 2'($urandom);
      set_pc_value   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 3) * 4))
                                                    : ($urandom & 32'hFFFF_FFFC);
      redirect_valid = ($urandom_range(0, 5) == 0);
      redirect_tid   = 2'($urandom);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      reset_n        = ($urandom_range(0, 99) != 0);
      tick();
    end

    reset_n = 1'b1; pc_en = 1'b1; thread_en = 4'b1111;
    set_pc_valid = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/thread_fetch_unit.md
Name: thread_fetch_unit

Overview:
- Parametrised fine-grained multithreaded PC/fetch sequencer that replaces the single-PC, issue-every-4th-cycle fetch logic.
- Holds one PC per hardware thread and picks one eligible thread per cycle, round-robin.
- Each issuing thread is locked out for BR_SHADOW cycles, so branch/jump redirects from the MEM stage land before that thread fetches again.
- Drives the i_mem read address and the IF/ID pipeline register.

Parameters:
- PC_WIDTH, 32: width of every PC and redirect address.
- NUM_THREADS, 4: number of hardware threads, 1..16.
- TID_WIDTH, 2: thread-id width; must equal max(1, ceil(log2(NUM_THREADS))).
- PC_STEP, 4: PC increment per fetch, in bytes.
- BR_SHADOW, 3: lockout cycles after a thread issues, 0..15.
- RESET_PC, 0: PC value loaded into every thread at reset.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset_n, input, 1: synchronous reset, active-low.
- pc_en, input, 1: global advance enable; 0 = stall.
- thread_en, input, NUM_THREADS: per-thread run enable.
- set_pc_valid, input, 1: host load of a thread PC.
- set_pc_tid, input, TID_WIDTH: thread to load.
- set_pc_value, input, PC_WIDTH: start PC.
- redirect_valid, input, 1: branch taken / jump, from MEM stage.
- redirect_tid, input, TID_WIDTH: thread being redirected.
- redirect_pc, input, PC_WIDTH: target address.
- fetch_valid, output, 1: fetch_pc/fetch_tid hold a real fetch.
- fetch_tid, output, TID_WIDTH: thread of the current fetch.
- fetch_pc, output, PC_WIDTH: address to i_mem.
- thread_ready, output, NUM_THREADS: per-thread eligible flags, combinational.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - pc[t]=RESET_PC and lock_cnt[t]=0 for all t; rr_ptr=0.
  - fetch_valid=0, fetch_tid=0, fetch_pc=0.
  - Reset overrides every other input in that cycle, including set_pc and redirect.
- Eligibility: elig[t] = thread_en[t] & (lock_cnt[t]==0) & !(redirect_valid & redirect_tid==t) & !(set_pc_valid & set_pc_tid==t). thread_ready = elig.
- Selection: first t with elig[t], scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_THREADS.
- Cycle with pc_en=1, thread s selected:
  - fetch_valid<=1, fetch_tid<=s, fetch_pc<=pc[s].
  - pc[s]<=pc[s]+PC_STEP, modulo 2^PC_WIDTH: 0xFFFFFFFC wraps to 0.
  - lock_cnt[s]<=BR_SHADOW.
  - rr_ptr<=(s+1) mod NUM_THREADS.
- Cycle with pc_en=1 and no eligible thread: fetch_valid<=0 (bubble); fetch_tid/fetch_pc hold; rr_ptr holds.
- Lock counters: when pc_en=1, every nonzero lock_cnt of a non-selected thread decrements by 1. With pc_en=0, counters hold.
- pc_en=0: pc[], rr_ptr, lock_cnt and all fetch outputs hold. Redirect and set_pc are still applied.
- Redirect (redirect_valid=1, redirect_tid<NUM_THREADS): pc[redirect_tid]<=redirect_pc. The thread is excluded from selection that cycle; its lock_cnt is unchanged.
- set_pc (set_pc_valid=1, set_pc_tid<NUM_THREADS): pc[tid]<=set_pc_value and lock_cnt[tid]<=0. Excluded from selection that cycle.
- Priority when set_pc and redirect hit the same thread: set_pc wins.
- Set/redirect on different threads in the same cycle: both are applied.
- tid >= NUM_THREADS on set_pc or redirect: ignored.
- thread_en[t] dropped: thread t stops issuing, but its PC and counter keep their values and semantics. Re-enabling resumes at the stored PC.
- Latency: fetch outputs are registered, 1 cycle after selection. A redirect takes effect on the thread's next fetch.
- NUM_THREADS=1, BR_SHADOW=3 reproduces one fetch every 4 cycles.
- Storage: no X on outputs after reset. PC storage is flops; it may be a register array.

Test Plan:
- NUM_THREADS=1, BR_SHADOW=3, thread_en=1, pc_en=1 from reset release -> fetch_valid pattern 1,0,0,0 repeating; fetch_pc 0x0, 0x4, 0x8 on the valid cycles.
- NUM_THREADS=4, BR_SHADOW=3, thread_en=4'b1111 -> fetch_valid=1 every cycle.
  - fetch_tid 0,1,2,3,0,...
  - The second round shows fetch_pc=0x4 for each thread.
- thread_en=4'b0101, BR_SHADOW=3:
  - fetch_tid sequence 0,2,bubble,bubble,0,2,...
  - thread 0 fetch_pc 0x0, 0x4, 0x8.
- 4 threads running; redirect_valid with tid=1, pc=0x100 one cycle after tid1 issues -> tid1's next fetch_pc=0x100, then 0x104. Other threads are unaffected.
- Stall and set_pc:
  - pc_en=0 for 3 cycles mid-stream -> outputs frozen; the sequence resumes exactly where it stopped.
  - set_pc and redirect to the same tid in the same cycle -> the set_pc value is used.
- Wrap and reset:
  - set_pc tid0 = 0xFFFFFFFC -> fetches 0xFFFFFFFC, then 0x0.
  - reset_n=0 mid-stream -> next cycle fetch_valid=0, all PCs=RESET_PC, first fetch is tid0.
